// File: rtl/bpsk_symbol_scheduler.sv
// BPSK frame scheduler: alternating preamble, MSB-first payload mapped to +/-AMP,
// then zero-level tail, each symbol held for SPS clocks with a first-sample strobe.
module bpsk_symbol_scheduler #(
    parameter int SPS          = 4,
    parameter int AMP          = 100,
    parameter int PREAMBLE_LEN = 8,
    parameter int TAIL_LEN     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [7:0] symbol_out,
    output logic       symbol_strobe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int TW   = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int CMAX = (PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [7:0] POS = AMP[7:0];
    localparam logic [7:0] NEG = 8'(-AMP);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_TAIL} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   sym_cnt_q, sym_cnt_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      fc_q, fc_d;
    logic [7:0]      bc_q, bc_d;
    logic            hv_q, hv_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            need_q, need_d;
    logic [7:0]      sym_q, sym_d;
    logic            strobe_q, strobe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            underrun_q, underrun_d;
    logic            pay_step;

    assign byte_ready    = busy_q & ~hv_q & (fc_q < len_q);
    assign symbol_out    = sym_q;
    assign symbol_strobe = strobe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign underrun      = underrun_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sym_cnt_d  = sym_cnt_q;
        len_d      = len_q;
        fc_d       = fc_q;
        bc_d       = bc_q;
        hv_d       = hv_q;
        hold_d     = hold_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        need_d     = need_q;
        sym_d      = sym_q;
        strobe_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        pay_step   = 1'b0;

        if (byte_valid && byte_ready) begin
            hv_d   = 1'b1;
            hold_d = byte_in;
            fc_d   = fc_q + 8'd1;
        end

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d   = S_PREAMBLE;
                len_d     = frame_len;
                timer_d   = '0;
                sym_cnt_d = '0;
                fc_d      = '0;
                bc_d      = '0;
                hv_d      = 1'b0;
                need_d    = 1'b1;
                sym_d     = POS;
                strobe_d  = 1'b1;
                busy_d    = 1'b1;
            end
        end else if (timer_q != TW'(SPS - 1)) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d  = '0;
            strobe_d = 1'b1;
            case (state_q)
                S_PREAMBLE: begin
                    if (sym_cnt_q == CW'(PREAMBLE_LEN - 1)) begin
                        sym_cnt_d = '0;
                        if (len_q == 8'd0) begin
                            state_d = S_TAIL;
                            sym_d   = '0;
                        end else begin
                            state_d  = S_PAYLOAD;
                            pay_step = 1'b1;
                        end
                    end else begin
                        sym_cnt_d = sym_cnt_q + CW'(1);
                        sym_d     = sym_cnt_q[0] ? POS : NEG;
                    end
                end
                S_PAYLOAD: pay_step = 1'b1;
                S_TAIL: begin
                    sym_d = '0;
                    if (sym_cnt_q == CW'(TAIL_LEN - 1)) begin
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        strobe_d  = 1'b0;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end

        // need_q marks a pending byte load (first payload symbol or an underrun retry)
        if (pay_step) begin
            if (!need_q && bit_cnt_q == 3'd0 && bc_q == len_q) begin
                state_d   = S_TAIL;
                sym_cnt_d = '0;
                sym_d     = '0;
            end else if (need_q || bit_cnt_q == 3'd0) begin
                if (hv_q) begin
                    shift_d   = hold_q;
                    bit_cnt_d = 3'd7;
                    sym_d     = hold_q[7] ? POS : NEG;
                    hv_d      = 1'b0;
                    bc_d      = bc_q + 8'd1;
                    need_d    = 1'b0;
                end else begin
                    sym_d      = '0;
                    underrun_d = 1'b1;
                    need_d     = 1'b1;
                end
            end else begin
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q - 3'd1;
                sym_d     = shift_q[6] ? POS : NEG;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            sym_cnt_q  <= '0;
            len_q      <= '0;
            fc_q       <= '0;
            bc_q       <= '0;
            hv_q       <= 1'b0;
            hold_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            need_q     <= 1'b0;
            sym_q      <= '0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sym_cnt_q  <= sym_cnt_d;
            len_q      <= len_d;
            fc_q       <= fc_d;
            bc_q       <= bc_d;
            hv_q       <= hv_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            need_q     <= need_d;
            sym_q      <= sym_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_bpsk_symbol_scheduler.sv
// Self-checking bench for bpsk_symbol_scheduler: a slot-level frame model predicts
// every output sample and every byte handshake cycle relative to the first strobe.
module tb_bpsk_symbol_scheduler;

    localparam int SPS  = 4;
    localparam int PRE  = 8;
    localparam int TAIL = 2;
    localparam logic [7:0] POS = 8'h64;
    localparam logic [7:0] NEG = 8'h9C;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] frame_len;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] symbol_out;
    logic       symbol_strobe;
    logic       busy;
    logic       done;
    logic       underrun;

    int tests = 0;
    int fails = 0;
    int ur_seen;

    logic [7:0] fr_bytes [0:15];
    int         fr_offer [0:15];
    logic [7:0] exp_sym [$];
    bit         exp_ur [$];
    int         exp_hs [$];

    always #5 clock = ~clock;

    bpsk_symbol_scheduler #(
        .SPS(SPS), .AMP(100), .PREAMBLE_LEN(PRE), .TAIL_LEN(TAIL)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .symbol_out(symbol_out), .symbol_strobe(symbol_strobe), .busy(busy),
        .done(done), .underrun(underrun)
    );

    // Symbol slot k occupies cycles SPS*k .. SPS*k+SPS-1; a byte handshaken in cycle h
    // can feed a slot starting at cycle b only if h <= b-2.
    task automatic build_model(input int len);
        int loaded, bits, b;
        logic [7:0] cur;
        exp_sym.delete(); exp_ur.delete(); exp_hs.delete();
        for (int k = 0; k < PRE; k++) begin
            exp_sym.push_back((k % 2 == 0) ? POS : NEG);
            exp_ur.push_back(1'b0);
        end
        if (len > 0) exp_hs.push_back(fr_offer[0]);
        loaded = 0; bits = 0; cur = '0;
        while (loaded < len || bits > 0) begin
            b = SPS * exp_sym.size();
            if (bits > 0) begin
                bits--;
                exp_sym.push_back(cur[bits] ? POS : NEG);
                exp_ur.push_back(1'b0);
            end else if (exp_hs[loaded] <= b - 2) begin
                cur = fr_bytes[loaded];
                exp_sym.push_back(cur[7] ? POS : NEG);
                exp_ur.push_back(1'b0);
                bits = 7;
                if (loaded + 1 < len)
                    exp_hs.push_back((fr_offer[loaded + 1] > b) ? fr_offer[loaded + 1] : b);
                loaded++;
            end else begin
                exp_sym.push_back(8'h00);
                exp_ur.push_back(1'b1);
            end
        end
        for (int k = 0; k < TAIL; k++) begin
            exp_sym.push_back(8'h00);
            exp_ur.push_back(1'b0);
        end
    endtask

    task automatic run_frame(input int len, input int abort_at, input int mid_start_at,
                             input bit hold_valid, input bit skip_start, input bit chain,
                             input int next_len, input string name);
        int n_cyc, last, hs_idx;
        logic [7:0] es;
        bit est, eur, ebusy, edone;
        build_model(len);
        n_cyc  = SPS * exp_sym.size();
        last   = (abort_at >= 0) ? abort_at + 4 : (chain ? n_cyc : n_cyc + 1);
        hs_idx = 0;
        ur_seen = 0;
        if (!skip_start) begin
            start = 1'b1;
            frame_len = 8'(len);
        end
        @(posedge clock); #1;
        start = 1'b0;
        frame_len = 8'($urandom);
        for (int c = 0; c <= last; c++) begin
            if (abort_at >= 0 && c > abort_at) begin
                es = '0; est = 0; eur = 0; ebusy = 0; edone = 0;
            end else if (c < n_cyc) begin
                es = exp_sym[c / SPS]; est = (c % SPS == 0); eur = est && exp_ur[c / SPS];
                ebusy = 1; edone = 0;
            end else if (c == n_cyc) begin
                es = '0; est = 0; eur = 0; ebusy = 0; edone = 1;
            end else begin
                es = '0; est = 0; eur = 0; ebusy = 0; edone = 0;
            end
            if (underrun === 1'b1) ur_seen++;
            tests++;
            if ({symbol_out, symbol_strobe, underrun, busy, done} !== {es, est, eur, ebusy, edone}) begin
                fails++;
                $display("FAIL %s cycle %0d: out/strobe/underrun/busy/done got %h/%b/%b/%b/%b expected %h/%b/%b/%b/%b",
                         name, c, symbol_out, symbol_strobe, underrun, busy, done, es, est, eur, ebusy, edone);
            end

            reset = (c == abort_at);
            start = (c == mid_start_at) || (chain && c == n_cyc);
            if (c == mid_start_at) frame_len = 8'd7;
            if (chain && c == n_cyc) frame_len = 8'(next_len);
            if (hold_valid) begin
                byte_valid = 1'b1;
                byte_in = (hs_idx < len) ? fr_bytes[hs_idx] : 8'hEE;
            end else if (hs_idx < len && c >= fr_offer[hs_idx] && (abort_at < 0 || c < abort_at)) begin
                byte_valid = 1'b1;
                byte_in = fr_bytes[hs_idx];
            end else begin
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
            end

            if (hs_idx >= len || (abort_at >= 0 && c > abort_at)) begin
                tests++;
                if (byte_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s ready_idle cycle %0d: byte_ready got %b expected 0", name, c, byte_ready);
                end
            end
            if (byte_valid && byte_ready) begin
                tests++;
                if (hs_idx >= len || c != exp_hs[hs_idx]) begin
                    fails++;
                    $display("FAIL %s handshake %0d: at cycle %0d expected cycle %0d", name, hs_idx, c,
                             (hs_idx < len) ? exp_hs[hs_idx] : -1);
                end
                hs_idx++;
            end
            if (c < last) begin
                @(posedge clock); #1;
            end
        end
        reset = 1'b0;
        if (abort_at < 0) begin
            tests++;
            if (hs_idx != len) begin
                fails++;
                $display("FAIL %s handshake_count: got %0d expected %0d", name, hs_idx, len);
            end
        end
        if (!chain) begin
            byte_valid = 1'b0;
            start = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; frame_len = '0; byte_in = '0; byte_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tests++;
            if ({symbol_out, symbol_strobe, busy, byte_ready, done, underrun} !== 13'd0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: out/strobe/busy/ready/done/underrun got %h/%b/%b/%b/%b/%b expected 00/0/0/0/0/0",
                         c, symbol_out, symbol_strobe, busy, byte_ready, done, underrun);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_single_byte();
        fr_bytes[0] = 8'hA5; fr_offer[0] = 0;
        byte_valid = 1'b1; byte_in = 8'hA5;
        run_frame(1, -1, -1, 1'b0, 1'b0, 1'b0, 0, "single_byte");
    endtask

    task automatic test_empty_frame();
        run_frame(0, -1, -1, 1'b0, 1'b0, 1'b0, 0, "empty_frame");
    endtask

    task automatic test_underrun();
        fr_bytes[0] = 8'hFF; fr_offer[0] = 0;
        fr_bytes[1] = 8'h00; fr_offer[1] = 74;
        run_frame(2, -1, -1, 1'b0, 1'b0, 1'b0, 0, "underrun");
        tests++;
        if (ur_seen != 3) begin
            fails++;
            $display("FAIL underrun_pulses: got %0d expected 3", ur_seen);
        end
    endtask

    task automatic test_hold_valid();
        for (int i = 0; i < 3; i++) begin
            fr_bytes[i] = 8'($urandom); fr_offer[i] = 0;
        end
        run_frame(3, -1, 50, 1'b1, 1'b0, 1'b0, 0, "hold_valid");
    endtask

    task automatic test_reset_mid();
        fr_bytes[0] = 8'h3C; fr_offer[0] = 0;
        fr_bytes[1] = 8'hC3; fr_offer[1] = 0;
        run_frame(2, 40, -1, 1'b0, 1'b0, 1'b0, 0, "reset_mid");
        fr_bytes[0] = 8'h5A; fr_offer[0] = 3;
        run_frame(1, -1, -1, 1'b0, 1'b0, 1'b0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        fr_bytes[0] = 8'h81; fr_offer[0] = 10;
        run_frame(1, -1, -1, 1'b0, 1'b0, 1'b1, 0, "b2b_first");
        run_frame(0, -1, -1, 1'b0, 1'b1, 1'b0, 0, "b2b_second");
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(0, 4);
            for (int i = 0; i < 16; i++) begin
                fr_bytes[i] = 8'($urandom);
                fr_offer[i] = (i == 0) ? $urandom_range(0, 40) : fr_offer[i - 1] + $urandom_range(0, 50);
            end
            run_frame(len, -1, -1, 1'b0, 1'b0, 1'b0, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_empty_frame();
        test_underrun();
        test_hold_valid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
